runway_light_sequencer: RTL

Parametrised runway landing-light sequencer driving NUM_LIGHTS lamps; the successor to the fixed 3-lamp landing-light FSM. It supports four modes: calm alternate, right-to-left chase, left-to-right chase, and a new bounce mode. A built-in step prescaler, a pause enable and a cycle-complete pulse are also new. It sits between the board switch/clock-select logic and the LEDR lamps.

---
 rtl/runway_light_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/runway_light_sequencer.sv
// rtl/runway_light_sequencer.sv - parametrised runway landing-light sequencer
//
// Purpose: drives NUM_LIGHTS lamps in one of four patterns (calm alternate,
// right-to-left chase, left-to-right chase, bounce), advancing one pattern
// step every STEP_DIV enabled clock cycles.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   mode       in   requested pattern: 00 calm, 01 r-to-l, 10 l-to-r, 11 bounce
//   enable     in   1 = run, 0 = freeze everything including the prescaler
//   out        out  lamp drive, bit 0 = rightmost lamp, 1 = on (registered)
//   cur_mode   out  pattern currently displayed (registered)
//   cycle_done out  one-cycle pulse after a pattern completes a cycle (registered)
module runway_light_sequencer #(
  parameter int NUM_LIGHTS = 8,
  parameter int STEP_DIV   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic                  enable,
  output logic [NUM_LIGHTS-1:0] out,
  output logic [1:0]            cur_mode,
  output logic                  cycle_done
);

  localparam int PW = $clog2(NUM_LIGHTS);
  // STEP_DIV = 1 needs no counter bits, but keep one so the vector is legal.
  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [PW-1:0] POS_MAX = PW'(NUM_LIGHTS - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STEP_DIV - 1);

  function automatic logic [NUM_LIGHTS-1:0] even_mask();
    logic [NUM_LIGHTS-1:0] m;
    for (int i = 0; i < NUM_LIGHTS; i++) m[i] = (i % 2 == 0);
    return m;
  endfunction

  localparam logic [NUM_LIGHTS-1:0] PHASE_A = even_mask();
  localparam logic [NUM_LIGHTS-1:0] PHASE_B = ~PHASE_A;
  localparam logic [NUM_LIGHTS-1:0] LAMP0   = NUM_LIGHTS'(1);

  typedef enum logic [1:0] {
    MODE_CALM   = 2'b00,
    MODE_R2L    = 2'b01,
    MODE_L2R    = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_e;

  mode_e                 mode_q, mode_d;
  logic                  phase_b_q, phase_b_d;
  logic [PW-1:0]         pos_q, pos_d;
  logic                  dir_down_q, dir_down_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_LIGHTS-1:0] out_q, out_d;
  logic                  done_q, done_d;
  logic                  step;

  assign step = enable && (cnt_q == CNT_MAX);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q     <= MODE_CALM;
      phase_b_q  <= 1'b0;
      pos_q      <= '0;
      dir_down_q <= 1'b0;
      cnt_q      <= '0;
      out_q      <= PHASE_A;
      done_q     <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      phase_b_q  <= phase_b_d;
      pos_q      <= pos_d;
      dir_down_q <= dir_down_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    mode_d     = mode_q;
    phase_b_d  = phase_b_q;
    pos_d      = pos_q;
    dir_down_d = dir_down_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;

    if (enable) cnt_d = step ? '0 : cnt_q + 1'b1;

    if (step) begin
      if (mode != mode_q) begin
        // A new mode only loads its start state; it does not advance.
        mode_d = mode_e'(mode);
        case (mode_e'(mode))
          MODE_CALM:   phase_b_d = 1'b0;
          MODE_R2L:    pos_d = '0;
          MODE_L2R:    pos_d = POS_MAX;
          MODE_BOUNCE: begin
            pos_d      = '0;
            dir_down_d = 1'b0;
          end
        endcase
      end else begin
        case (mode_q)
          MODE_CALM: begin
            phase_b_d = ~phase_b_q;
            done_d    = phase_b_q;
          end
          MODE_R2L: begin
            if (pos_q == POS_MAX) begin
              pos_d  = '0;
              done_d = 1'b1;
            end else begin
              pos_d = pos_q + 1'b1;
            end
          end
          MODE_L2R: begin
            if (pos_q == '0) begin
              pos_d  = POS_MAX;
              done_d = 1'b1;
            end else begin
              pos_d = pos_q - 1'b1;
            end
          end
          MODE_BOUNCE: begin
            // dir flips on the step that lands on an endpoint so each
            // endpoint lamp is shown for exactly one step.
            if (!dir_down_q) begin
              pos_d = pos_q + 1'b1;
              if (pos_q == POS_MAX - 1'b1) dir_down_d = 1'b1;
            end else begin
              pos_d = pos_q - 1'b1;
              if (pos_q == PW'(1)) begin
                dir_down_d = 1'b0;
                done_d     = 1'b1;
              end
            end
          end
        endcase
      end
    end

    out_d = (mode_d == MODE_CALM) ? (phase_b_d ? PHASE_B : PHASE_A)
                                  : (LAMP0 << pos_d);
  end

  // Outputs
  always_comb begin
    out        = out_q;
    cur_mode   = mode_q;
    cycle_done = done_q;
  end

endmodule
